axi_redirect_sequencer: RTL

Configuration sequencer for the AW address decoder's port-redirect (swap) function. It queues redirect programming requests and blocks new write addresses. It waits until all outstanding write transactions drain, then atomically updates the registered source/target/redirect_valid triple that drives the decoder's swap stage. A drain timeout aborts a stuck request and flags a sticky error.

---
 rtl/axi_redirect_sequencer.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/axi_redirect_sequencer.sv
// Sequencer for the AW decoder port-redirect stage: queues redirect requests, blocks
// new write addresses, waits for outstanding writes to drain, then updates the swap triple.
module axi_redirect_sequencer #(
  parameter int unsigned N_INIT_PORT   = 8,
  parameter int unsigned LOG_N_INIT    = 3,
  parameter int unsigned QUEUE_DEPTH   = 4,
  parameter int unsigned DRAIN_TIMEOUT = 256,
  parameter int unsigned TO_WIDTH      = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_valid_i,
  output logic                  cfg_ready_o,
  input  logic                  cfg_enable_i,
  input  logic [LOG_N_INIT-1:0] cfg_source_i,
  input  logic [LOG_N_INIT-1:0] cfg_target_i,
  output logic                  cfg_invalid_o,
  input  logic                  outstanding_trans_i,
  output logic                  block_aw_o,
  output logic [LOG_N_INIT-1:0] source_r_o,
  output logic [LOG_N_INIT-1:0] target_r_o,
  output logic                  redirect_valid_r_o,
  output logic                  update_done_o,
  output logic                  timeout_err_o,
  input  logic                  err_clr_i,
  output logic                  busy_o
);

  localparam int unsigned PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH + 1);

  typedef struct packed {
    logic                  enable;
    logic [LOG_N_INIT-1:0] source;
    logic [LOG_N_INIT-1:0] target;
  } req_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLOCK = 2'd1,
    DRAIN = 2'd2,
    APPLY = 2'd3
  } state_e;

  state_e              state_q, state_d;
  req_t                queue_q [QUEUE_DEPTH];
  req_t                req_in;
  req_t                head;
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [TO_WIDTH-1:0] to_cnt_q, to_cnt_d;

  logic ready_q, invalid_q, block_q, done_q, busy_q, err_q;
  logic [LOG_N_INIT-1:0] source_q, target_q;
  logic                  valid_q;

  logic accept, illegal, push, pop, apply, timeout_set;

  // Request validation at acceptance; illegal requests complete the handshake but are dropped
  always_comb begin
    illegal = cfg_enable_i &&
              ((cfg_source_i == cfg_target_i) ||
               (32'(cfg_source_i) >= N_INIT_PORT) ||
               (32'(cfg_target_i) >= N_INIT_PORT));
    accept  = cfg_valid_i && ready_q;
    push    = accept && !illegal;
    req_in  = '{enable: cfg_enable_i, source: cfg_source_i, target: cfg_target_i};
    head    = queue_q[rd_ptr_q];
  end

  // Occupancy bookkeeping; push and pop together leave the count unchanged
  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push && pop) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Next-state logic for the block/drain/apply sequence
  always_comb begin
    state_d     = state_q;
    to_cnt_d    = to_cnt_q;
    pop         = 1'b0;
    apply       = 1'b0;
    timeout_set = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (count_q != '0) state_d = BLOCK;
      end
      BLOCK: begin
        // One guard cycle lets an in-flight AW handshake land in the outstanding count
        to_cnt_d = '0;
        state_d  = DRAIN;
      end
      DRAIN: begin
        if (!outstanding_trans_i) begin
          state_d = APPLY;
        end else if ((DRAIN_TIMEOUT != 0) &&
                     (to_cnt_q == TO_WIDTH'(DRAIN_TIMEOUT - 1))) begin
          pop         = 1'b1;
          timeout_set = 1'b1;
          state_d     = IDLE;
        end else begin
          to_cnt_d = to_cnt_q + TO_WIDTH'(1);
        end
      end
      APPLY: begin
        pop     = 1'b1;
        apply   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Queue storage needs no reset; only entries below the count are ever read
  always_ff @(posedge clk) begin
    if (push) queue_q[wr_ptr_q] <= req_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      to_cnt_q  <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ready_q   <= 1'b1;
      invalid_q <= 1'b0;
      block_q   <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      source_q  <= '0;
      target_q  <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      to_cnt_q  <= to_cnt_d;
      count_q   <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      ready_q   <= (count_d != CNT_W'(QUEUE_DEPTH));
      invalid_q <= accept && illegal;
      block_q   <= (state_d != IDLE);
      done_q    <= (state_d == APPLY);
      busy_q    <= (state_d != IDLE) || (count_d != '0);
      // Set has priority over a same-cycle clear
      err_q     <= timeout_set || (err_q && !err_clr_i);
      if (apply) begin
        if (head.enable) begin
          source_q <= head.source;
          target_q <= head.target;
          valid_q  <= 1'b1;
        end else begin
          source_q <= '0;
          target_q <= '0;
          valid_q  <= 1'b0;
        end
      end
    end
  end

  assign cfg_ready_o        = ready_q;
  assign cfg_invalid_o      = invalid_q;
  assign block_aw_o         = block_q;
  assign update_done_o      = done_q;
  assign busy_o             = busy_q;
  assign timeout_err_o      = err_q;
  assign source_r_o         = source_q;
  assign target_r_o         = target_q;
  assign redirect_valid_r_o = valid_q;

endmodule
